axi_frame_writer: RTL and testbench

AXI_FRAME_WRITER -- requirements
Module: axi_frame_writer

---
 rtl/axi_frame_writer.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_frame_writer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_frame_writer.sv
// Streams a fixed-length frame of 64-bit beats into memory as a sequence of AXI3 INCR bursts.
// An internal first-word-fall-through FIFO decouples the input stream from the write channel.
`timescale 1ns/1ps
module axi_frame_writer #(
  parameter int BURST_LEN  = 16,
  parameter int NBEATS     = 1000,
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_OUTST  = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic        in_val_i,
  input  logic [63:0] in_data_i,
  output logic        in_rdy_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_awaddr,
  output logic [3:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic [1:0]  m_axi_awlock,
  output logic [3:0]  m_axi_awcache,
  output logic [2:0]  m_axi_awprot,
  output logic [3:0]  m_axi_awqos,
  output logic [5:0]  m_axi_awid,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  output logic [63:0] m_axi_wdata,
  output logic [7:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic [5:0]  m_axi_wid,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  input  logic [1:0]  m_axi_bresp,
  input  logic [5:0]  m_axi_bid
);
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DRAIN = 2'd3} state_t;

  localparam int NW = $clog2(NBEATS) + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  state_t          state_r, state_s;
  logic [31:0]     addr_r, paddr_r;
  logic [NW-1:0]   left_r, in_cnt_r;
  logic [BW-1:0]   blen_r, bcnt_r, burst_l_s;
  logic [OW-1:0]   outst_r;
  logic [FW-1:0]   fcnt_r;
  logic [PW-1:0]   wptr_r, rptr_r;
  logic [63:0]     mem_r [FIFO_DEPTH];
  logic            err_r, done_r, pend_r, done_set_s;
  logic            fifo_full_s, fifo_empty_s, push_s, pop_s;
  logic            aw_valid_s, aw_hs_s, w_valid_s, w_hs_s, wlast_s, b_hs_s;
  logic            hold_s, restart_s;
  logic            unused_s;

  // Length of the next burst: a full burst, or whatever remains of the frame.
  always_comb begin
    if (32'(left_r) > 32'(BURST_LEN)) begin
      burst_l_s = BW'(BURST_LEN);
    end else begin
      burst_l_s = BW'(left_r);
    end
  end

  assign fifo_full_s  = (fcnt_r == FW'(FIFO_DEPTH));
  assign fifo_empty_s = (fcnt_r == {FW{1'b0}});
  assign busy_o       = (state_r != IDLE);
  assign in_rdy_o     = busy_o & ~fifo_full_s & (in_cnt_r != NW'(NBEATS));
  assign push_s       = in_val_i & in_rdy_o;
  assign aw_valid_s   = (state_r == ADDR) & (32'(fcnt_r) >= 32'(burst_l_s))
                        & (outst_r != OW'(MAX_OUTST));
  assign aw_hs_s      = aw_valid_s & m_axi_awready;
  assign w_valid_s    = (state_r == DATA) & ~fifo_empty_s;
  assign w_hs_s       = w_valid_s & m_axi_wready;
  assign wlast_s      = w_valid_s & (bcnt_r == (blen_r - BW'(1)));
  assign pop_s        = w_hs_s;
  assign b_hs_s       = m_axi_bvalid;
  // A start that arrives while a valid is waiting for ready is deferred until that handshake ends.
  assign hold_s       = (aw_valid_s & ~m_axi_awready) | (w_valid_s & ~m_axi_wready);
  assign restart_s    = (start_i | pend_r) & ~hold_s;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and frame-complete detection.
  always_comb begin
    state_s    = state_r;
    done_set_s = 1'b0;
    if (restart_s) begin
      state_s = ADDR;
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        ADDR: begin
          if (aw_hs_s) state_s = DATA;
          else         state_s = ADDR;
        end
        DATA: begin
          if (w_hs_s && wlast_s) begin
            if (left_r != {NW{1'b0}}) state_s = ADDR;
            else                      state_s = DRAIN;
          end else begin
            state_s = DATA;
          end
        end
        DRAIN: begin
          if (outst_r == {OW{1'b0}}) begin
            state_s    = IDLE;
            done_set_s = 1'b1;
          end else begin
            state_s = DRAIN;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Frame counters, address, FIFO pointers and status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_r <= 32'h0;   paddr_r <= 32'h0;
      left_r <= {NW{1'b0}}; in_cnt_r <= {NW{1'b0}};
      blen_r <= {BW{1'b0}}; bcnt_r <= {BW{1'b0}};
      outst_r <= {OW{1'b0}}; fcnt_r <= {FW{1'b0}};
      wptr_r <= {PW{1'b0}}; rptr_r <= {PW{1'b0}};
      err_r <= 1'b0; done_r <= 1'b0; pend_r <= 1'b0;
    end else begin
      done_r <= done_set_s;
      // Outstanding bursts reflect the bus, so they survive a restart and drain normally.
      case ({aw_hs_s, b_hs_s})
        2'b10:   outst_r <= outst_r + OW'(1);
        2'b01:   outst_r <= (outst_r != {OW{1'b0}}) ? outst_r - OW'(1) : outst_r;
        default: outst_r <= outst_r;
      endcase
      if (restart_s) begin
        addr_r   <= start_i ? addr_i : paddr_r;
        left_r   <= NW'(NBEATS);
        in_cnt_r <= {NW{1'b0}};
        blen_r   <= {BW{1'b0}};
        bcnt_r   <= {BW{1'b0}};
        fcnt_r   <= {FW{1'b0}};
        wptr_r   <= {PW{1'b0}};
        rptr_r   <= {PW{1'b0}};
        err_r    <= 1'b0;
        pend_r   <= 1'b0;
      end else begin
        if (start_i) begin
          pend_r  <= 1'b1;
          paddr_r <= addr_i;
        end else begin
          pend_r  <= pend_r;
        end
        if (push_s) begin
          wptr_r   <= wptr_r + PW'(1);
          in_cnt_r <= in_cnt_r + NW'(1);
        end else begin
          wptr_r   <= wptr_r;
        end
        if (pop_s) rptr_r <= rptr_r + PW'(1);
        else       rptr_r <= rptr_r;
        case ({push_s, pop_s})
          2'b10:   fcnt_r <= fcnt_r + FW'(1);
          2'b01:   fcnt_r <= fcnt_r - FW'(1);
          default: fcnt_r <= fcnt_r;
        endcase
        if (aw_hs_s) begin
          addr_r <= addr_r + (32'(burst_l_s) << 3);
          left_r <= left_r - NW'(burst_l_s);
          blen_r <= burst_l_s;
          bcnt_r <= {BW{1'b0}};
        end else if (w_hs_s) begin
          bcnt_r <= bcnt_r + BW'(1);
        end else begin
          bcnt_r <= bcnt_r;
        end
        if (b_hs_s && (m_axi_bresp != 2'b00)) err_r <= 1'b1;
        else                                  err_r <= err_r;
      end
    end
  end

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wptr_r] <= in_data_i;
    end
  end

  assign done_o        = done_r;
  assign err_o         = err_r;
  assign m_axi_awvalid = aw_valid_s;
  assign m_axi_awaddr  = addr_r;
  assign m_axi_awlen   = 4'(burst_l_s - BW'(1));
  assign m_axi_awsize  = 3'b011;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 2'b00;
  assign m_axi_awcache = 4'b0000;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_awid    = 6'd0;
  assign m_axi_wvalid  = w_valid_s;
  assign m_axi_wdata   = mem_r[rptr_r];
  assign m_axi_wstrb   = 8'hFF;
  assign m_axi_wlast   = wlast_s;
  assign m_axi_wid     = 6'd0;
  assign m_axi_bready  = 1'b1;
  assign unused_s      = ^m_axi_bid;
endmodule

// File: tb/tb_axi_frame_writer.sv
// Scoreboard bench for axi_frame_writer: expected AW/W traffic is queued as frames are started
// and input beats are accepted, then popped and compared as the DUT issues them.
`timescale 1ns/1ps
module tb_axi_frame_writer;
  localparam int BL = 16;
  localparam int NB = 40;
  localparam int FD = 64;
  localparam int MO = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni, start_i, in_val_i, in_rdy_o, busy_o, done_o, err_o;
  logic [31:0] addr_i;
  logic [63:0] in_data_i;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [3:0]  m_axi_awlen, m_axi_awcache, m_axi_awqos;
  logic [2:0]  m_axi_awsize, m_axi_awprot;
  logic [1:0]  m_axi_awburst, m_axi_awlock, m_axi_bresp;
  logic [5:0]  m_axi_awid, m_axi_wid, m_axi_bid;
  logic        m_axi_wvalid, m_axi_wready, m_axi_wlast, m_axi_bvalid, m_axi_bready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;

  always #5 clk_i = ~clk_i;

  axi_frame_writer #(.BURST_LEN(BL), .NBEATS(NB), .FIFO_DEPTH(FD), .MAX_OUTST(MO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .addr_i(addr_i),
    .in_val_i(in_val_i), .in_data_i(in_data_i), .in_rdy_o(in_rdy_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awqos(m_axi_awqos), .m_axi_awid(m_axi_awid),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wid(m_axi_wid),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bid(m_axi_bid)
  );

  typedef struct packed { logic [31:0] addr; logic [3:0] len; } aw_t;
  typedef struct packed { logic [63:0] data; logic last; } w_t;

  aw_t         aw_exp[$];
  w_t          w_exp[$];
  bit          b_q[$];
  bit          b_hold = 1'b0, rand_rdy = 1'b0;
  int          err_burst = -1;
  int          in_beats = 0, aw_cnt = 0, w_cnt = 0;
  int          n_checks = 0, n_errors = 0;
  bit          aw_stall = 1'b0, w_stall = 1'b0;
  logic [35:0] aw_prev;
  logic [63:0] w_prev_data;
  logic        w_prev_last;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ctl"}, {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, in_rdy_o, busy_o, done_o, err_o}, 7'd0);
    check_val({tag, "_awaddr"}, m_axi_awaddr, 32'h0);
  endtask

  // Monitor: stall stability, scoreboard push on input accept, pop/compare on AW and W handshakes.
  always @(negedge clk_i) begin
    aw_t a;
    w_t  w;
    if (!rst_ni) begin
      aw_stall = 1'b0;
      w_stall  = 1'b0;
    end else begin
      if (aw_stall) begin
        check_val("aw_hold_valid", m_axi_awvalid, 1'b1);
        check_val("aw_hold_addr_len", {m_axi_awaddr, m_axi_awlen}, aw_prev);
      end
      if (w_stall) begin
        check_val("w_hold_ctl", {m_axi_wvalid, m_axi_wlast}, {1'b1, w_prev_last});
        check_val("w_hold_data", m_axi_wdata, w_prev_data);
      end
      aw_stall    = m_axi_awvalid & ~m_axi_awready;
      aw_prev     = {m_axi_awaddr, m_axi_awlen};
      w_stall     = m_axi_wvalid & ~m_axi_wready;
      w_prev_data = m_axi_wdata;
      w_prev_last = m_axi_wlast;
      if (in_val_i && in_rdy_o) begin
        w.data = in_data_i;
        w.last = ((in_beats % BL) == BL - 1) || (in_beats == NB - 1);
        w_exp.push_back(w);
        in_beats++;
      end
      if (m_axi_awvalid && m_axi_awready) begin
        check_val("aw_expected_pending", aw_exp.size() != 0, 1'b1);
        if (aw_exp.size() != 0) begin
          a = aw_exp.pop_front();
          check_val("aw_addr", m_axi_awaddr, a.addr);
          check_val("aw_len", m_axi_awlen, a.len);
        end
        b_q.push_back(aw_cnt == err_burst);
        aw_cnt++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        check_val("w_expected_pending", w_exp.size() != 0, 1'b1);
        if (w_exp.size() != 0) begin
          w = w_exp.pop_front();
          check_val("w_data", m_axi_wdata, w.data);
          check_val("w_last", m_axi_wlast, w.last);
        end
        w_cnt++;
      end
    end
  end

  // Input source: fresh random data every cycle, occasional gaps in random mode.
  initial begin
    in_val_i = 1'b0; in_data_i = 64'h0;
    forever begin
      @(posedge clk_i); #1;
      in_data_i = {$urandom, $urandom};
      in_val_i  = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Slave ready generation.
  initial begin
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      m_axi_awready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_wready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // B responder: one response per accepted AW, withheld while b_hold is set.
  initial begin
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; m_axi_bid = 6'd0;
    forever begin
      @(posedge clk_i); #1;
      if (m_axi_bvalid && b_q.size() > 0) void'(b_q.pop_front());
      if (!b_hold && rst_ni && b_q.size() > 0) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = b_q[0] ? 2'b10 : 2'b00;
      end else begin
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
      end
    end
  end

  task automatic start_frame(input logic [31:0] base, input bit rnd, input int errb, input bit hold_b);
    aw_t a;
    int  rem, off, l;
    bit  seen;
    rand_rdy = rnd; err_burst = errb;
    aw_exp.delete(); w_exp.delete();
    in_beats = 0; aw_cnt = 0; w_cnt = 0;
    rem = NB; off = 0;
    while (rem > 0) begin
      l = (rem > BL) ? BL : rem;
      a.addr = base + 32'(off * 8);
      a.len  = 4'(l - 1);
      aw_exp.push_back(a);
      rem -= l; off += l;
    end
    b_hold = hold_b;
    @(posedge clk_i); #1;
    start_i = 1'b1; addr_i = base;
    @(posedge clk_i); #1;
    start_i = 1'b0; addr_i = 32'h0;
    @(negedge clk_i);
    check_val("busy_after_start", busy_o, 1'b1);
    check_val("err_cleared_by_start", err_o, 1'b0);
    check_val("aw_consts", {m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache,
                            m_axi_awprot, m_axi_awqos, m_axi_awid}, {3'b011, 2'b01, 19'd0});
    check_val("w_b_consts", {m_axi_wstrb, m_axi_wid, m_axi_bready}, {8'hFF, 6'd0, 1'b1});
    if (hold_b) begin
      seen = 1'b0;
      for (int c = 0; c < 1000 && !seen; c++) begin
        @(negedge clk_i);
        seen = (aw_cnt >= MO);
      end
      check_val("bursts_before_limit", seen, 1'b1);
      repeat (30) @(negedge clk_i);
      check_val("third_aw_blocked", m_axi_awvalid, 1'b0);
      check_val("aw_count_at_limit", aw_cnt, MO);
      b_hold = 1'b0;
    end
  endtask

  task automatic wait_done(input bit exp_err);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk_i);
      seen = done_o;
    end
    check_val("done_seen", seen, 1'b1);
    check_val("busy_at_done", busy_o, 1'b0);
    check_val("err_at_done", err_o, exp_err);
    check_val("beats_accepted", in_beats, NB);
    check_val("aw_all_issued", aw_exp.size(), 0);
    check_val("w_all_issued", w_exp.size(), 0);
    @(negedge clk_i);
    check_val("done_one_cycle", done_o, 1'b0);
    check_val("err_sticky", err_o, exp_err);
  endtask

  initial begin
    bit seen;
    rst_ni = 1'b0; start_i = 1'b0; addr_i = 32'h0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check_val("idle_before_start", {in_rdy_o, busy_o, m_axi_awvalid, done_o}, 4'd0);
    end

    start_frame(32'h0000_1000, 1'b0, -1, 1'b0);
    wait_done(1'b0);
    start_frame(32'h0000_4000, 1'b1, -1, 1'b0);
    wait_done(1'b0);
    start_frame(32'h0000_8000, 1'b0, 0, 1'b0);
    wait_done(1'b1);
    start_frame(32'h0000_1000, 1'b0, -1, 1'b1);
    wait_done(1'b0);

    start_frame(32'h0000_2000, 1'b0, -1, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk_i);
      seen = (w_cnt >= 3);
    end
    check_val("reached_data", seen, 1'b1);
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    b_q.delete();
    m_axi_bvalid = 1'b0;
    #1;
    check_reset_outputs("reset_mid_data");
    aw_exp.delete(); w_exp.delete();
    repeat (3) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check_val("idle_after_reset", {in_rdy_o, busy_o, m_axi_awvalid, m_axi_wvalid}, 4'd0);
    end
    start_frame(32'h0000_3000, 1'b1, -1, 1'b0);
    wait_done(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
